// File: rtl/fetch_queue.sv
// fetch_queue: instruction fetch front end with a prefetch FIFO.
// Holds the fetch PC, issues one outstanding imem request at a time over a
// req/ack handshake, buffers returned words with their PC+4, and feeds IF/ID
// one instruction per cycle with stall and branch-redirect flush.
// Optional feature macro: FETCH_BYPASS_EN (ack data forwarded straight to the
// outputs when the FIFO is empty).
module fetch_queue #(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic                     clock,
  input  logic                     reset,
  output logic                     imem_req,
  output logic [31:0]              imem_addr,
  input  logic                     imem_ack,
  input  logic [31:0]              imem_rdata,
  input  logic                     redirect,
  input  logic [31:0]              redirect_pc,
  input  logic                     stall,
  output logic                     inst_valid,
  output logic [31:0]              inst,
  output logic [31:0]              pc_next,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL = CW'(DEPTH);

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DISCARD} state_t;

  state_t          r_state, w_state_nxt;
  logic [31:0]     r_fetch_pc, r_req_pc;
  logic [31:0]     r_inst_mem [DEPTH];
  logic [31:0]     r_pcn_mem  [DEPTH];
  logic [AW-1:0]   r_rd_ptr, r_wr_ptr;
  logic [CW-1:0]   r_count;

  logic [31:0]     w_req_pc4;
  logic            w_ack_ok, w_fifo_valid, w_push, w_pop;

  assign w_req_pc4    = r_req_pc + 32'd4;
  // an ack only carries live data while waiting and not being flushed
  assign w_ack_ok     = (r_state == S_WAIT) && imem_ack && !redirect;
  assign w_fifo_valid = (r_count != '0);
  assign w_pop        = w_fifo_valid && !stall && !redirect;

  assign imem_req  = (r_state == S_IDLE) && !reset && !redirect && (r_count < FULL);
  assign imem_addr = r_fetch_pc;
  assign count     = r_count;

`ifdef FETCH_BYPASS_EN
  logic w_byp;
  // empty FIFO: the returning word is presented in its own ack cycle
  assign w_byp      = w_ack_ok && !w_fifo_valid;
  // a bypassed word that is consumed immediately never enters the FIFO
  assign w_push     = w_ack_ok && !(w_byp && !stall);
  assign inst_valid = !reset && (w_fifo_valid || w_byp);
  assign inst       = reset ? 32'h0 : w_fifo_valid ? r_inst_mem[r_rd_ptr] :
                      w_byp ? imem_rdata : 32'h0;
  assign pc_next    = reset ? 32'h0 : w_fifo_valid ? r_pcn_mem[r_rd_ptr] :
                      w_byp ? w_req_pc4 : 32'h0;
`else
  assign w_push     = w_ack_ok;
  assign inst_valid = !reset && w_fifo_valid;
  assign inst       = inst_valid ? r_inst_mem[r_rd_ptr] : 32'h0;
  assign pc_next    = inst_valid ? r_pcn_mem[r_rd_ptr]  : 32'h0;
`endif

  // next-state: request/response handshake with stale-response discard
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE:    if (imem_req) w_state_nxt = S_WAIT;
      S_WAIT: begin
        if (redirect)      w_state_nxt = imem_ack ? S_IDLE : S_DISCARD;
        else if (imem_ack) w_state_nxt = S_IDLE;
      end
      S_DISCARD: if (imem_ack) w_state_nxt = S_IDLE;
      default:   w_state_nxt = S_IDLE;
    endcase
  end

  // state register
  always_ff @(posedge clock) begin
    if (reset) r_state <= S_IDLE;
    else       r_state <= w_state_nxt;
  end

  // fetch PC: redirect wins over sequential advance; PC+4 wraps at 2^32
  always_ff @(posedge clock) begin
    if (reset) begin
      r_fetch_pc <= RESET_PC;
      r_req_pc   <= RESET_PC;
    end else if (redirect) begin
      r_fetch_pc <= redirect_pc;
    end else if (imem_req) begin
      r_fetch_pc <= r_fetch_pc + 32'd4;
      r_req_pc   <= r_fetch_pc;
    end
  end

  // FIFO pointers and occupancy; redirect flushes everything
  always_ff @(posedge clock) begin
    if (reset || redirect) begin
      r_rd_ptr <= '0;
      r_wr_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + AW'(1);
      if (w_pop)  r_rd_ptr <= r_rd_ptr + AW'(1);
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  // FIFO storage: instruction word and its PC+4
  always_ff @(posedge clock) begin
    if (w_push && !reset) begin
      r_inst_mem[r_wr_ptr] <= imem_rdata;
      r_pcn_mem[r_wr_ptr]  <= w_req_pc4;
    end
  end
endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction fetch front end with a prefetch FIFO. It sits upstream of the IF/ID pipeline register and replaces the bare PC register plus combinational instruction-memory path. It holds the fetch PC, issues one-outstanding requests to instruction memory over a req/ack handshake, and buffers returned words with their PC+4. It delivers one instruction per cycle to IF/ID, honours a downstream stall, and flushes on a branch redirect (PCSrc).

## Interface
Parameters:
- DEPTH, 4: FIFO entries, power of two, ≥2.
- RESET_PC, 32'h0: fetch PC loaded on reset.

Ports:
- clock  in  1  single clock, all state on rising edge.
- reset  in  1  synchronous, active-high.
- imem_req  out  1  fetch request; memory captures imem_addr on the edge where imem_req=1.
- imem_addr  out  32  word address of request (fetch_pc).
- imem_ack  in  1  one-cycle pulse, response valid, ≥1 cycle after the request edge.
- imem_rdata  in  32  instruction word, valid with imem_ack.
- redirect  in  1  branch taken (PCSrc); flush and refetch.
- redirect_pc  in  32  branch target.
- stall  in  1  IF/ID hold; head entry is not consumed.
- inst_valid  out  1  head entry valid.
- inst  out  32  head instruction; 32'h0 (nop) when not valid.
- pc_next  out  32  head instruction PC+4; 32'h0 when not valid.
- count  out  $clog2(DEPTH)+1  FIFO occupancy.

## Operation
- States: IDLE (no request outstanding), WAIT (request outstanding, response wanted), DISCARD (request outstanding, response stale).
- imem_req = (state==IDLE) && !reset && !redirect && (count + 0 < DEPTH). Only one request is ever outstanding, so the reserved slot always exists at push.
- IDLE, imem_req=1 at edge: fetch_pc += 4, recorded req_pc = old fetch_pc, go WAIT.
- WAIT, imem_ack, no redirect: push {imem_rdata, req_pc+4}, go IDLE.
- WAIT, redirect (with or without ack): drop any ack, fetch_pc ← redirect_pc, FIFO cleared; go IDLE if ack same cycle, else DISCARD.
- DISCARD, imem_ack: data dropped, go IDLE. DISCARD, redirect: fetch_pc ← redirect_pc, stay DISCARD.
- IDLE, redirect: fetch_pc ← redirect_pc, FIFO cleared, no request that cycle.
- imem_ack in IDLE is ignored (covers stale responses after reset).
- Pop when inst_valid && !stall && !redirect. Push and pop in the same cycle: count unchanged. Redirect overrides both.
- Arithmetic: 32-bit, PC+4 wraps 32'hFFFFFFFC → 32'h0 silently.

## Timing
- Reset (synchronous): state IDLE, fetch_pc=RESET_PC, FIFO empty, count=0, inst_valid=0, inst=0, pc_next=0, imem_req=0 while reset high.
- First request is issued in the first cycle after reset deasserts.
- Latency, no bypass: request edge t, ack in cycle t+k, inst_valid=1 in cycle t+k+1.
- Redirect in cycle r: inst_valid=0 in r+1; earliest new request in r+1 (from IDLE) or the cycle after the stale ack (from DISCARD).
- Throughput with 1-cycle memory: one instruction every 2 cycles, because req and ack cannot overlap.
- Full FIFO (count=DEPTH): imem_req=0 until a pop occurs.

## Configuration
- FETCH_BYPASS_EN defined: when the FIFO is empty and an accepted imem_ack arrives in WAIT, inst_valid/inst/pc_next are driven combinationally from imem_rdata/req_pc+4 in that cycle. If !stall, the word is consumed without being pushed; if stall, it is pushed as normal. Latency drops by one cycle.
- Undefined: all outputs come from FIFO registers only; no combinational path from imem_* to inst_*.

## Test plan
- Reset with RESET_PC=32'h100, memory ack 1 cycle later → addresses 100,104,108 issued in order; inst/pc_next = mem[100]/32'h104 first; inst_valid=0, inst=0 during reset.
- Hold stall=1 with DEPTH=4 → count reaches 4, imem_req=0; release stall → one pop per cycle and requests resume, with no lost or duplicated words.
- Redirect to 32'h200 while in WAIT, ack 2 cycles later → stale word dropped, next address 32'h200, FIFO empties in the next cycle.
- Redirect and imem_ack in the same cycle → word dropped, state IDLE, next imem_addr = redirect_pc.
- Assert reset mid-WAIT, then an ack in the first cycle after reset → ack ignored, count=0, first address RESET_PC.
- fetch_pc=32'hFFFFFFFC → pc_next=32'h0, next imem_addr=32'h0. Build with FETCH_BYPASS_EN → inst_valid in the ack cycle when the FIFO is empty.
